nes_snes_poll_engine: RTL and testbench
=======================================

// Module: nes_snes_poll_engine
// PURPOSE
//   Drives the latch/clock pins of a NES or SNES game controller and shifts in its
//   serial button word. It sits directly upstream of the TinyQV controller peripheral
//   register map and supplies a decoded, active-high button word plus a connected flag.
//   Polling runs autonomously at a fixed rate, or on demand.
// PARAMETERS
//   HALF_PERIOD  384      clk cycles per half bit-period (6 us at 64 MHz); legal range >= 8
//   POLL_PERIOD  1066667  clk cycles between automatic poll starts (~60 Hz at 64 MHz)
//   NUM_BITS     16       bits shifted per frame (16 for SNES; also valid for NES, extra bits read 1)
// PORTS
//   clk            in   1         system clock (64 MHz)
//   rst            in   1         reset; one clock; reset is asynchronous and active-high
//   enable         in   1         1 = automatic polling on POLL_PERIOD timer
//   poll_now       in   1         single-cycle request to start a frame immediately
//   ctrl_data      in   1         controller serial data, active-low pressed; board pull-down
//   ctrl_latch     out  1         latch pulse to controller
//   ctrl_clk       out  1         shift clock to controller, idles low
//   buttons        out  NUM_BITS  active-high pressed; bit k = k-th bit shifted in
//   connected      out  1         1 = last frame saw at least one 1 on ctrl_data
//   buttons_valid  out  1         one-cycle pulse when buttons/connected update
//   busy           out  1         1 while a frame is in progress
// BEHAVIOUR
//   Reset:
//     - All outputs are 0; counters, shift register and synchronizer are cleared.
//     - Asynchronous assert aborts any frame; pins drop low the same instant.
//   Input sync:
//     - ctrl_data passes a 2-flop synchronizer before sampling (2-cycle delay).
//   Poll timer:
//     - Free-running counter 0..POLL_PERIOD-1, running regardless of enable.
//     - At wrap, a start request is raised if enable=1.
//   Start:
//     - A start request or a poll_now pulse in IDLE begins a frame next cycle.
//     - Requests arriving while busy are dropped, not queued.
//     - A simultaneous timer wrap and poll_now start exactly one frame.
//   FSM (bit counter k, half-period counter h, 0..HALF_PERIOD-1):
//     IDLE   : latch=0, clk=0, busy=0.
//     LATCH  : latch=1 for 2*HALF_PERIOD cycles -> WAIT.
//     WAIT   : latch=0 for HALF_PERIOD cycles; on the last cycle sample bit 0 -> CLK_HI
//              (-> DONE if NUM_BITS=1).
//     CLK_HI : clk=1 for HALF_PERIOD cycles -> CLK_LO.
//     CLK_LO : clk=0 for HALF_PERIOD cycles; on the last cycle sample bit k, k++;
//              k==NUM_BITS-1 sampled -> DONE, else -> CLK_HI.
//     DONE   : one cycle; update outputs, pulse buttons_valid -> IDLE.
//   Frame length: 3*HALF_PERIOD + (NUM_BITS-1)*2*HALF_PERIOD + 1 cycles.
//     Default values give 12673 cycles.
//   Output rules:
//     - Sampled bit k is stored inverted into shift[k].
//     - Outputs are registered; they change only in DONE.
//     - If all raw samples = 0 (unplugged, pull-down): connected=0 and buttons forced to 0.
//     - Otherwise connected=1 and buttons = shift.
//     - buttons hold their value between frames.
//   Enable:
//     - Deasserting enable mid-frame does not abort; the frame completes and updates outputs.
//   busy = (state != IDLE).
//   Glitch-free pins: ctrl_latch and ctrl_clk are driven straight from flops.
// TESTING
//   1. Controller model with raw word 16'hFFFE (B pressed), poll_now pulse
//      -> one latch of 768 cycles, 15 clk pulses, buttons=16'h0001, connected=1,
//         buttons_valid 12673 cycles after start.
//   2. ctrl_data held 0 (unplugged), poll_now
//      -> buttons=0, connected=0, one valid pulse.
//   3. enable=1 with POLL_PERIOD=20000 for 3 periods, raw word 16'hF0FF
//      -> 3 frames at 20000-cycle spacing, buttons=16'h0F00 each time.
//   4. poll_now every 1000 cycles while busy
//      -> requests ignored; exactly one valid pulse per frame; latch never re-asserts mid-frame.
//   5. rst asserted during CLK_HI of bit 7
//      -> ctrl_clk/latch/buttons/valid=0 immediately; after release, IDLE until next request.
//   6. Simultaneous timer wrap and poll_now
//      -> exactly one frame started.

Source files
------------

// File: rtl/nes_snes_poll_engine.sv
// nes_snes_poll_engine
// Drives the latch/clock pins of a NES or SNES pad and shifts in its serial
// button word. It produces an active-high button word and a connected flag.
// Frames start from a free-running poll timer (when enabled) or on demand.
module nes_snes_poll_engine #(
  parameter int HALF_PERIOD = 384,
  parameter int POLL_PERIOD = 1066667,
  parameter int NUM_BITS    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                poll_now,
  input  logic                ctrl_data,
  output logic                ctrl_latch,
  output logic                ctrl_clk,
  output logic [NUM_BITS-1:0] buttons,
  output logic                connected,
  output logic                buttons_valid,
  output logic                busy
);

  localparam int HW = $clog2(2 * HALF_PERIOD + 1);
  localparam int PW = $clog2(POLL_PERIOD + 1);
  localparam int KW = $clog2(NUM_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_WAIT,
    S_CLK_HI,
    S_CLK_LO,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [HW-1:0]       h_cnt, h_nxt;
  logic [KW-1:0]       k_cnt, k_nxt;
  logic [PW-1:0]       timer;
  logic                timer_wrap;
  logic                start_req;
  logic                data_meta, data_sync;
  logic [NUM_BITS-1:0] shift;
  logic                any_one;
  logic                sample_en;
  logic                load_out;
  logic                clear_frame;

  assign timer_wrap = (timer == PW'(POLL_PERIOD - 1));
  assign start_req  = poll_now | (enable & timer_wrap);
  assign busy       = (state != S_IDLE);

  // Two-flop synchronizer for the asynchronous controller data line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_meta <= 1'b0;
      data_sync <= 1'b0;
    end else begin
      data_meta <= ctrl_data;
      data_sync <= data_meta;
    end
  end

  // Free-running poll timer; it keeps counting even while polling is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (timer_wrap) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // State, half-period and bit-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      h_cnt <= '0;
      k_cnt <= '0;
    end else begin
      state <= state_nxt;
      h_cnt <= h_nxt;
      k_cnt <= k_nxt;
    end
  end

  // Next-state logic: sequences latch, settle and clock phases of one frame
  always_comb begin
    state_nxt   = state;
    h_nxt       = h_cnt + 1'b1;
    k_nxt       = k_cnt;
    sample_en   = 1'b0;
    load_out    = 1'b0;
    clear_frame = 1'b0;
    case (state)
      S_IDLE: begin
        h_nxt = '0;
        if (start_req) begin
          state_nxt   = S_LATCH;
          k_nxt       = '0;
          clear_frame = 1'b1;
        end
      end
      S_LATCH: begin
        if (h_cnt == HW'(2 * HALF_PERIOD - 1)) begin
          h_nxt     = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (h_cnt == HW'(HALF_PERIOD - 1)) begin
          h_nxt     = '0;
          sample_en = 1'b1;
          k_nxt     = k_cnt + 1'b1;
          state_nxt = (NUM_BITS == 1) ? S_DONE : S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        if (h_cnt == HW'(HALF_PERIOD - 1)) begin
          h_nxt     = '0;
          state_nxt = S_CLK_LO;
        end
      end
      S_CLK_LO: begin
        if (h_cnt == HW'(HALF_PERIOD - 1)) begin
          h_nxt     = '0;
          sample_en = 1'b1;
          k_nxt     = k_cnt + 1'b1;
          state_nxt = (k_cnt == KW'(NUM_BITS - 1)) ? S_DONE : S_CLK_HI;
        end
      end
      S_DONE: begin
        h_nxt     = '0;
        load_out  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        h_nxt     = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Pins come straight from flops that follow the upcoming state, so they stay glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_latch <= 1'b0;
      ctrl_clk   <= 1'b0;
    end else begin
      ctrl_latch <= (state_nxt == S_LATCH);
      ctrl_clk   <= (state_nxt == S_CLK_HI);
    end
  end

  // Capture each sampled bit inverted and remember whether any raw 1 was seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= '0;
      any_one <= 1'b0;
    end else if (clear_frame) begin
      shift   <= '0;
      any_one <= 1'b0;
    end else if (sample_en) begin
      for (int i = 0; i < NUM_BITS; i++) begin
        if (k_cnt == KW'(i)) begin
          shift[i] <= ~data_sync;
        end
      end
      any_one <= any_one | data_sync;
    end
  end

  // Publish the frame result once at the end; an all-zero line means no pad is plugged in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buttons       <= '0;
      connected     <= 1'b0;
      buttons_valid <= 1'b0;
    end else begin
      buttons_valid <= load_out;
      if (load_out) begin
        connected <= any_one;
        buttons   <= any_one ? shift : '0;
      end
    end
  end

endmodule

// File: tb/tb_nes_snes_poll_engine.sv
// Testbench for nes_snes_poll_engine: a pad model feeds serial data, a reference
// model predicts each frame's result and arrival cycle, a monitor checks them.
module tb_nes_snes_poll_engine;

  localparam int H     = 8;
  localparam int P     = 600;
  localparam int N     = 16;
  localparam int FRAME = 3 * H + (N - 1) * 2 * H + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          poll_now;
  logic          ctrl_data;
  logic          ctrl_latch;
  logic          ctrl_clk;
  logic [N-1:0]  buttons;
  logic          connected;
  logic          buttons_valid;
  logic          busy;

  nes_snes_poll_engine #(
    .HALF_PERIOD(H),
    .POLL_PERIOD(P),
    .NUM_BITS(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .poll_now(poll_now),
    .ctrl_data(ctrl_data),
    .ctrl_latch(ctrl_latch),
    .ctrl_clk(ctrl_clk),
    .buttons(buttons),
    .connected(connected),
    .buttons_valid(buttons_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] b;
    logic         c;
    int unsigned  due;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int unsigned cyc = 0;
  int unsigned tmodel = 0;
  int unsigned busy_until = 0;
  int          valid_count = 0;
  int          latch_cyc = 0;
  int          latch_rise = 0;
  int          clk_rise = 0;
  logic        prev_l = 1'b0;
  logic        prev_c = 1'b0;
  bit          wrap;

  // Pad model: raw word (0 = pressed), loaded while latch is high, shifted on clk rise
  logic [N-1:0] word = '1;
  logic         plugged = 1'b1;
  logic [N-1:0] sr = '1;
  logic         prev_pin_clk = 1'b0;

  always @(posedge clk) begin
    prev_pin_clk <= ctrl_clk;
    if (ctrl_latch) sr <= word;
    else if (ctrl_clk && !prev_pin_clk) sr <= {1'b1, sr[N-1:1]};
  end
  assign ctrl_data = plugged ? sr[0] : 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: free-running timer, one frame per accepted request, fixed latency
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      tmodel = 0;
      busy_until = 0;
      exp_q.delete();
    end else begin
      wrap = (tmodel == P - 1);
      tmodel = wrap ? 0 : tmodel + 1;
      if ((poll_now || (enable && wrap)) && cyc > busy_until) begin
        exp_t e;
        if (!plugged || word == '0) begin
          e.b = '0;
          e.c = 1'b0;
        end else begin
          e.b = ~word;
          e.c = 1'b1;
        end
        e.due = cyc + FRAME;
        exp_q.push_back(e);
        busy_until = cyc + FRAME;
      end
    end
  end

  // Monitor: pin activity per frame and scoreboard comparison on each valid pulse
  always @(negedge clk) begin
    if (rst) begin
      latch_cyc = 0; latch_rise = 0; clk_rise = 0;
      prev_l = 1'b0; prev_c = 1'b0;
    end else begin
      if (ctrl_latch) latch_cyc++;
      if (ctrl_latch && !prev_l) latch_rise++;
      if (ctrl_clk && !prev_c) clk_rise++;
      prev_l = ctrl_latch;
      prev_c = ctrl_clk;
      if (buttons_valid) begin
        valid_count++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_valid: got valid=1 expected no frame (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("buttons", 32'(buttons), 32'(e.b));
          check_output("connected", 32'(connected), 32'(e.c));
          check_output("valid_cycle", cyc, e.due);
          check_output("latch_width", latch_cyc, 2 * H);
          check_output("latch_pulses", latch_rise, 1);
          check_output("clk_pulses", clk_rise, N - 1);
          check_output("busy_after_done", 32'(busy), 0);
        end
        latch_cyc = 0; latch_rise = 0; clk_rise = 0;
      end
    end
  end

  task automatic wait_frames(input int n, input int limit);
    int target;
    target = valid_count + n;
    for (int i = 0; i < limit && valid_count < target; i++) @(negedge clk);
    @(negedge clk);
    check_output("frame_count", valid_count, target);
  endtask

  task automatic apply_stimulus(input logic [N-1:0] w, input logic p);
    @(negedge clk);
    word = w;
    plugged = p;
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    wait_frames(1, FRAME + 20);
  endtask

  initial begin
    int base;
    rst = 1'b1; enable = 1'b0; poll_now = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_buttons", 32'(buttons), 0);
    check_output("rst_connected", 32'(connected), 0);
    check_output("rst_valid", 32'(buttons_valid), 0);
    check_output("rst_latch", 32'(ctrl_latch), 0);
    check_output("rst_clk", 32'(ctrl_clk), 0);
    check_output("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] single poll, B pressed");
    apply_stimulus(16'hFFFE, 1'b1);
    $display("[TB] unplugged pad");
    apply_stimulus(16'h0000, 1'b0);
    $display("[TB] random words");
    for (int i = 0; i < 6; i++) apply_stimulus(N'($urandom), 1'b1);
    apply_stimulus(16'h0000, 1'b1);
    apply_stimulus(16'hFFFF, 1'b1);

    $display("[TB] automatic polling");
    word = 16'hF0FF;
    enable = 1'b1;
    wait_frames(3, 4 * P);
    enable = 1'b0;
    repeat (FRAME + 10) @(negedge clk);

    $display("[TB] enable dropped mid-frame");
    word = N'($urandom);
    enable = 1'b1;
    for (int i = 0; i < 2 * P && !busy; i++) @(negedge clk);
    enable = 1'b0;
    wait_frames(1, FRAME + 20);

    $display("[TB] requests while busy");
    base = valid_count;
    word = N'($urandom);
    @(negedge clk);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (49) @(negedge clk);
      poll_now = busy;
      @(negedge clk);
      poll_now = 1'b0;
    end
    repeat (2 * FRAME) @(negedge clk);
    check_output("busy_requests_frames", valid_count - base, 1);

    $display("[TB] reset mid-frame");
    base = valid_count;
    @(negedge clk);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    for (int i = 0; i < FRAME && !(clk_rise == 7 && ctrl_clk); i++) @(negedge clk);
    check_output("reached_bit7", clk_rise, 7);
    #2 rst = 1'b1;
    #1;
    check_output("arst_clk", 32'(ctrl_clk), 0);
    check_output("arst_latch", 32'(ctrl_latch), 0);
    check_output("arst_buttons", 32'(buttons), 0);
    check_output("arst_valid", 32'(buttons_valid), 0);
    check_output("arst_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    check_output("idle_after_reset", 32'(busy), 0);
    check_output("no_frame_after_reset", valid_count - base, 0);
    apply_stimulus(16'hFFFE, 1'b1);

    $display("[TB] timer wrap coinciding with poll_now");
    base = valid_count;
    for (int i = 0; i < 2 * P && tmodel != P - 1; i++) @(negedge clk);
    enable = 1'b1;
    poll_now = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    poll_now = 1'b0;
    repeat (FRAME + 50) @(negedge clk);
    check_output("simultaneous_frames", valid_count - base, 1);

    check_output("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
